memory_writeback_stage: RTL

MEMORY_WRITEBACK_STAGE -- requirements
Module: memory_writeback_stage

---
 rtl/memory_writeback_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/memory_writeback_stage.sv
// Memory / writeback pipeline stage.
// Holds the word-addressed data memory, which has an asynchronous read and a
// clocked write. The M/W pipeline register sits here, along with the
// writeback result mux fed from that register.
module memory_writeback_stage #(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_write_m,
   input  logic        reg_write_m,
   input  logic [1:0]  result_src_m,
   input  logic [4:0]  rd_m,
   input  logic [31:0] alu_result_m,
   input  logic [31:0] write_data_m,
   input  logic [31:0] pc_plus_4_m,
   output logic        reg_write_w,
   output logic [4:0]  rd_w,
   output logic [31:0] result_w,
   output logic        misaligned_w,
   output logic [31:0] read_data_m
);

   localparam int AW = $clog2(MEM_WORDS);

   localparam logic [1:0] SRC_ALU  = 2'b00;
   localparam logic [1:0] SRC_LOAD = 2'b01;
   localparam logic [1:0] SRC_LINK = 2'b10;

   // A word access must have zero byte offset; loads and stores both count.
   function automatic logic access_misaligned(input logic [1:0] byte_off,
                                              input logic       is_store,
                                              input logic [1:0] src);
      return (byte_off != 2'b00) && (is_store || (src == SRC_LOAD));
   endfunction

   // The writeback mux. The reserved encoding returns zero so that nothing
   // undefined can reach the register file.
   function automatic logic [31:0] wb_select(input logic [1:0]  src,
                                             input logic [31:0] alu_val,
                                             input logic [31:0] load_val,
                                             input logic [31:0] link_val);
      logic [31:0] sel;
      case (src)
         SRC_ALU:  sel = alu_val;
         SRC_LOAD: sel = load_val;
         SRC_LINK: sel = link_val;
         default:  sel = 32'h0;
      endcase
      return sel;
   endfunction

   logic [31:0]   mem [MEM_WORDS];
   logic [AW-1:0] word_idx;
   logic          store_aligned;
   logic          reg_write_qual;
   logic          misaligned_m;

   // W-stage register contents.
   logic [31:0]   alu_result_p1;
   logic [31:0]   read_data_p1;
   logic [31:0]   pc_plus_4_p1;
   logic [1:0]    result_src_p1;
   logic [4:0]    rd_p1;
   logic          reg_write_p1;
   logic          misaligned_p1;

   // Upper address bits are dropped, so the address space wraps onto the array.
   assign word_idx       = alu_result_m[AW+1:2];
   assign store_aligned  = mem_write_m && (alu_result_m[1:0] == 2'b00);
   assign reg_write_qual = reg_write_m && (rd_m != 5'd0);
   assign misaligned_m   = access_misaligned(alu_result_m[1:0], mem_write_m, result_src_m);

   // The read is asynchronous. A misaligned load still returns the truncated word.
   assign read_data_m = mem[word_idx];

   // Store port. Memory contents survive reset, but no store happens on an
   // edge where reset is low. This covers a store that was pending when
   // reset went low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
      end else if (store_aligned) begin
         mem[word_idx] <= write_data_m;
      end
   end

   // ---- M -> W stage boundary ----
   // The M/W register advances every cycle because this stage never stalls or flushes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_result_p1 <= 32'h0;
         read_data_p1  <= 32'h0;
         pc_plus_4_p1  <= 32'h0;
         result_src_p1 <= 2'b00;
         rd_p1         <= 5'd0;
         reg_write_p1  <= 1'b0;
         misaligned_p1 <= 1'b0;
      end else begin
         alu_result_p1 <= alu_result_m;
         read_data_p1  <= read_data_m;
         pc_plus_4_p1  <= pc_plus_4_m;
         result_src_p1 <= result_src_m;
         rd_p1         <= rd_m;
         reg_write_p1  <= reg_write_qual;
         misaligned_p1 <= misaligned_m;
      end
   end

   assign reg_write_w  = reg_write_p1;
   assign rd_w         = rd_p1;
   assign misaligned_w = misaligned_p1;
   assign result_w     = wb_select(result_src_p1, alu_result_p1, read_data_p1, pc_plus_4_p1);

endmodule
